// File: rtl/l15_scratch_responder_pkg.sv
// l15_scratch_responder_pkg
// Purpose: shared constants for the L1.5 scratch responder. These are the
//          request/return type codes, the access size codes, the L15 AMO
//          operation codes, the FSM state encoding and the registered request
//          record.
// Ports:   none (package).
// Config:  the AMO datapath in the top is compiled only when
//          L15_RESPONDER_AMO_EN is defined.
package l15_scratch_responder_pkg;

  localparam int PHY_ADDR_WIDTH   = 40;
  localparam int L15_AMO_OP_WIDTH = 4;

  // Request types
  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [4:0] RQ_AMO   = 5'b00110;

  // Return types
  localparam logic [3:0] RT_LOAD_RET   = 4'b0000;
  localparam logic [3:0] RT_ATOMIC_RET = 4'b0011;
  localparam logic [3:0] RT_ST_ACK     = 4'b0100;

  // Access sizes
  localparam logic [2:0] SZ_1B = 3'b000;
  localparam logic [2:0] SZ_2B = 3'b001;
  localparam logic [2:0] SZ_4B = 3'b010;
  localparam logic [2:0] SZ_8B = 3'b011;

  // AMO operations
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_NONE = 4'b0000;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_LR   = 4'b0001;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_SC   = 4'b0010;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_SWAP = 4'b0011;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_ADD  = 4'b0100;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_AND  = 4'b0101;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_OR   = 4'b0110;
  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_XOR  = 4'b0111;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Request fields captured on accept. The word index is kept separately
  // because its width depends on DEPTH.
  typedef struct packed {
    logic [4:0]                  rqtype;
    logic [L15_AMO_OP_WIDTH-1:0] amo_op;
    logic [2:0]                  size;
    logic [2:0]                  off;
    logic [63:0]                 data;
  } req_t;

endpackage

// File: rtl/l15_scratch_responder_if.sv
// l15_scratch_responder_if
// Purpose: the core-side transducer <-> L1.5 request/response signal bundle.
// Modports:
//   master - the transducer. It drives the request and req_ack, and it sees
//            ack/val/returntype/data.
//   slave  - the L1.5 stand-in, which is the other end of the same signals.
interface l15_scratch_responder_if;
  import l15_scratch_responder_pkg::*;

  logic                        transducer_l15_val;
  logic [4:0]                  transducer_l15_rqtype;
  logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op;
  logic [2:0]                  transducer_l15_size;
  logic [PHY_ADDR_WIDTH-1:0]   transducer_l15_address;
  logic [63:0]                 transducer_l15_data;
  logic                        transducer_l15_nc;
  logic                        l15_transducer_ack;
  logic                        l15_transducer_header_ack;
  logic                        l15_transducer_val;
  logic [3:0]                  l15_transducer_returntype;
  logic [63:0]                 l15_transducer_data_0;
  logic [63:0]                 l15_transducer_data_1;
  logic                        transducer_l15_req_ack;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_amo_op,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_nc, transducer_l15_req_ack,
    input  l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_amo_op,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_nc, transducer_l15_req_ack,
    output l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1
  );
endinterface

// File: rtl/l15_scratch_lane_mask.sv
// l15_scratch_lane_mask
// Purpose: byte-lane mask for a sized access. Bit k of the mask is lane k
//          (address offset k, data bits [63-8k -: 8]). The access starts at
//          the offset rounded down to a multiple of the size.
// Ports:
//   i_size    - access size code (1/2/4/8 bytes; codes >= 3'b100 invalid)
//   i_offset  - address[2:0]
//   o_mask    - lanes covered by the access (all zero for an invalid size)
//   o_size_ok - size code is one of the four legal sizes
module l15_scratch_lane_mask
  import l15_scratch_responder_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [2:0] i_offset,
  output logic [7:0] o_mask,
  output logic       o_size_ok
);

  logic [3:0] w_start;
  logic [3:0] w_end;

  always_comb begin
    w_start = 4'd0;
    w_end   = 4'd0;
    case (i_size)
      SZ_1B: begin w_start = {1'b0, i_offset};              w_end = w_start + 4'd1; end
      SZ_2B: begin w_start = {1'b0, i_offset[2:1], 1'b0};   w_end = w_start + 4'd2; end
      SZ_4B: begin w_start = {1'b0, i_offset[2], 2'b00};    w_end = w_start + 4'd4; end
      SZ_8B: begin w_start = 4'd0;                          w_end = 4'd8;           end
      default: ;
    endcase
  end

  assign o_size_ok = ~i_size[2];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign o_mask[gi] = (4'(gi) >= w_start) && (4'(gi) < w_end);
    end
  endgenerate

endmodule

// File: rtl/l15_scratch_responder.sv
// l15_scratch_responder
// Purpose: behavioural L1.5 stand-in. It accepts one request at a time,
//          acks it and services it from a DEPTH x 64-bit scratch memory.
//          After RESP_LAT idle cycles it raises a response and holds that
//          response until req_ack.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset (clears FSM, outputs and memory)
//   l15_bus - slave side of l15_scratch_responder_if
// Parameters: DEPTH (words, power of two >= 2), RESP_LAT (0..255).
// Config: define L15_RESPONDER_AMO_EN to compile the AMO datapath (ADD, AND,
//         OR, XOR, SWAP on 4B/8B). Without it, AMO is an unknown request
//         type.
module l15_scratch_responder
  import l15_scratch_responder_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int RESP_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  l15_scratch_responder_if.slave  l15_bus
);

  localparam int IDXW = $clog2(DEPTH);
  // WAIT is never entered when RESP_LAT is 0, so that value of LAT_LAST is
  // unused.
  localparam logic [7:0] LAT_LAST = (RESP_LAT == 0) ? 8'd0 : 8'(RESP_LAT - 1);

  logic [1:0]      r_state;
  logic [7:0]      r_cnt;
  req_t            r_req;
  logic [IDXW-1:0] r_idx;
  logic [3:0]      r_rtype;
  logic [63:0]     r_data_0;
  logic [63:0]     r_data_1;
  logic [63:0]     r_mem [DEPTH];

  logic [7:0]      w_mask;
  logic            w_size_ok;
  logic [63:0]     w_bitmask;
  logic [63:0]     w_old;
  logic [IDXW-1:0] w_even;
  logic [IDXW-1:0] w_odd;
  logic            w_mem_we;
  logic [63:0]     w_mem_wdata;
  logic [3:0]      w_rtype;
  logic [63:0]     w_d0;
  logic [63:0]     w_d1;
  logic            w_unused;

  l15_scratch_lane_mask u_lane_mask (
    .i_size    (r_req.size),
    .i_offset  (r_req.off),
    .o_mask    (w_mask),
    .o_size_ok (w_size_ok)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bitmask
      assign w_bitmask[63-8*gi -: 8] = {8{w_mask[gi]}};
    end
  endgenerate

  assign w_old  = r_mem[r_idx];
  // A load returns the aligned pair that contains the addressed word.
  assign w_even = r_idx & ~IDXW'(1);
  assign w_odd  = r_idx | IDXW'(1);

`ifdef L15_RESPONDER_AMO_EN
  logic [63:0] w_amo_a;
  logic [63:0] w_amo_b;
  logic [63:0] w_amo_r;
  logic [63:0] w_amo_field;
  logic        w_amo_ok;

  // A 4B operand is moved down to bit 0 so that ADD carries stay inside the
  // field. The result is then moved back to its lane position.
  always_comb begin
    if (r_req.size == SZ_8B) begin
      w_amo_a = w_old;
      w_amo_b = r_req.data;
    end else if (r_req.off[2]) begin
      w_amo_a = {32'b0, w_old[31:0]};
      w_amo_b = {32'b0, r_req.data[31:0]};
    end else begin
      w_amo_a = {32'b0, w_old[63:32]};
      w_amo_b = {32'b0, r_req.data[63:32]};
    end
    w_amo_ok = (r_req.size == SZ_4B) || (r_req.size == SZ_8B);
    case (r_req.amo_op)
      L15_AMO_OP_ADD:  w_amo_r = w_amo_a + w_amo_b;
      L15_AMO_OP_AND:  w_amo_r = w_amo_a & w_amo_b;
      L15_AMO_OP_OR:   w_amo_r = w_amo_a | w_amo_b;
      L15_AMO_OP_XOR:  w_amo_r = w_amo_a ^ w_amo_b;
      L15_AMO_OP_SWAP: w_amo_r = w_amo_b;
      default: begin
        w_amo_r  = w_amo_a;
        w_amo_ok = 1'b0;
      end
    endcase
    if (r_req.size == SZ_8B)  w_amo_field = w_amo_r;
    else if (r_req.off[2])    w_amo_field = {32'b0, w_amo_r[31:0]};
    else                      w_amo_field = {w_amo_r[31:0], 32'b0};
  end
`endif

  // Response and memory-write values, which are committed on the ACK edge.
  // Any request with an illegal size code falls through to ST_ACK with no
  // effect.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_wdata = w_old;
    w_rtype     = RT_ST_ACK;
    w_d0        = '0;
    w_d1        = '0;
    if (w_size_ok) begin
      case (r_req.rqtype)
        RQ_LOAD: begin
          w_rtype = RT_LOAD_RET;
          w_d0    = r_mem[w_even];
          w_d1    = r_mem[w_odd];
        end
        RQ_STORE: begin
          w_mem_we    = 1'b1;
          w_mem_wdata = (w_old & ~w_bitmask) | (r_req.data & w_bitmask);
        end
`ifdef L15_RESPONDER_AMO_EN
        RQ_AMO: begin
          w_rtype     = RT_ATOMIC_RET;
          w_d0        = w_old & w_bitmask;
          w_mem_we    = w_amo_ok;
          w_mem_wdata = (w_old & ~w_bitmask) | (w_amo_field & w_bitmask);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_req    <= '0;
      r_idx    <= '0;
      r_rtype  <= '0;
      r_data_0 <= '0;
      r_data_1 <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (l15_bus.transducer_l15_val) begin
            r_req.rqtype <= l15_bus.transducer_l15_rqtype;
            r_req.amo_op <= l15_bus.transducer_l15_amo_op;
            r_req.size   <= l15_bus.transducer_l15_size;
            r_req.off    <= l15_bus.transducer_l15_address[2:0];
            r_req.data   <= l15_bus.transducer_l15_data;
            r_idx        <= l15_bus.transducer_l15_address[3 +: IDXW];
            r_state      <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (w_mem_we) r_mem[r_idx] <= w_mem_wdata;
          r_rtype  <= w_rtype;
          r_data_0 <= w_d0;
          r_data_1 <= w_d1;
          r_cnt    <= '0;
          r_state  <= (RESP_LAT == 0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == LAT_LAST) r_state <= ST_RESP;
          else                   r_cnt   <= r_cnt + 8'd1;
        end
        default: begin
          if (l15_bus.transducer_l15_req_ack) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign l15_bus.l15_transducer_ack        = (r_state == ST_ACK);
  assign l15_bus.l15_transducer_header_ack = (r_state == ST_ACK);
  assign l15_bus.l15_transducer_val        = (r_state == ST_RESP);
  assign l15_bus.l15_transducer_returntype = r_rtype;
  assign l15_bus.l15_transducer_data_0     = r_data_0;
  assign l15_bus.l15_transducer_data_1     = r_data_1;

  // The non-cacheable hint and the address bits above the index have no
  // effect. The AMO op is dead when the AMO datapath is not compiled.
  assign w_unused = &{1'b0, l15_bus.transducer_l15_nc, r_req.amo_op,
                      l15_bus.transducer_l15_address[PHY_ADDR_WIDTH-1:IDXW+3]};

endmodule

// File: tb/tb_l15_scratch_responder.sv
module tb_l15_scratch_responder;
  import l15_scratch_responder_pkg::*;

  localparam int RESP_LAT = 2;
  localparam logic [63:0] M1 = 64'h012345AA_DEADBEEF;
`ifdef L15_RESPONDER_AMO_EN
  localparam logic [63:0] M0 = 64'h0000000C_EEEEEEEE;
`else
  localparam logic [63:0] M0 = 64'h00000007_11111111;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  l15_scratch_responder_if bus ();

  l15_scratch_responder #(.DEPTH(16), .RESP_LAT(RESP_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .l15_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] addr,
                       input logic [63:0] wd, input logic [3:0] op);
    bus.transducer_l15_rqtype  = rq;
    bus.transducer_l15_size    = sz;
    bus.transducer_l15_address = addr;
    bus.transducer_l15_data    = wd;
    bus.transducer_l15_amo_op  = op;
    bus.transducer_l15_val     = 1'b1;
  endtask

  // Issue a request, check the ack/response latencies and the response
  // contents, and stop at the first cycle of RESP.
  task automatic issue(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] addr,
                       input logic [63:0] wd, input logic [3:0] op,
                       input logic [3:0] ert, input logic [63:0] ed0, input logic [63:0] ed1);
    int n;
    drive(rq, sz, addr, wd, op);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.l15_transducer_ack && n < 20);
    chk("ack_latency", 64'(n), 64'd1);
    chk("header_ack", 64'(bus.l15_transducer_header_ack), 64'd1);
    bus.transducer_l15_val = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.l15_transducer_val && n < 300);
    chk("resp_latency", 64'(n), 64'(RESP_LAT + 1));
    chk("returntype", 64'(bus.l15_transducer_returntype), 64'(ert));
    chk("data_0", bus.l15_transducer_data_0, ed0);
    chk("data_1", bus.l15_transducer_data_1, ed1);
    $display("txn rq=%b size=%b addr=%h wdata=%h -> rtype=%b d0=%h d1=%h", rq, sz, addr, wd,
             bus.l15_transducer_returntype, bus.l15_transducer_data_0, bus.l15_transducer_data_1);
  endtask

  // Leave the response un-consumed and check that it stays put with no new
  // ack.
  task automatic hold_resp(input int cycles, input logic [3:0] ert,
                           input logic [63:0] ed0, input logic [63:0] ed1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("hold_val", 64'(bus.l15_transducer_val), 64'd1);
      chk("hold_rtype", 64'(bus.l15_transducer_returntype), 64'(ert));
      chk("hold_d0", bus.l15_transducer_data_0, ed0);
      chk("hold_d1", bus.l15_transducer_data_1, ed1);
      chk("hold_no_ack", 64'(bus.l15_transducer_ack), 64'd0);
    end
  endtask

  task automatic ack_resp();
    bus.transducer_l15_req_ack = 1'b1;
    @(posedge clk); #1;
    bus.transducer_l15_req_ack = 1'b0;
    chk("val_drop", 64'(bus.l15_transducer_val), 64'd0);
    chk("no_ack_after_release", 64'(bus.l15_transducer_ack), 64'd0);
  endtask

  task automatic txn(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] addr,
                     input logic [63:0] wd, input logic [3:0] op,
                     input logic [3:0] ert, input logic [63:0] ed0, input logic [63:0] ed1);
    issue(rq, sz, addr, wd, op, ert, ed0, ed1);
    ack_resp();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"}, 64'(bus.l15_transducer_ack), 64'd0);
    chk({tag, "_hdr"}, 64'(bus.l15_transducer_header_ack), 64'd0);
    chk({tag, "_val"}, 64'(bus.l15_transducer_val), 64'd0);
    chk({tag, "_rtype"}, 64'(bus.l15_transducer_returntype), 64'd0);
    chk({tag, "_d0"}, bus.l15_transducer_data_0, 64'd0);
    chk({tag, "_d1"}, bus.l15_transducer_data_1, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.transducer_l15_val     = 1'b0;
    bus.transducer_l15_rqtype  = '0;
    bus.transducer_l15_amo_op  = '0;
    bus.transducer_l15_size    = '0;
    bus.transducer_l15_address = '0;
    bus.transducer_l15_data    = '0;
    bus.transducer_l15_nc      = 1'b0;
    bus.transducer_l15_req_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // A LOAD from reset is all zero. req_ack is held high outside RESP,
    // where it must be ignored.
    bus.transducer_l15_req_ack = 1'b1;
    txn(RQ_LOAD, SZ_8B, 40'h10, 64'd0, 4'd0, RT_LOAD_RET, 64'd0, 64'd0);

    // Full-word store, then a load of the pair.
    txn(RQ_STORE, SZ_8B, 40'h08, 64'h01234567_89ABCDEF, 4'd0, RT_ST_ACK, 64'd0, 64'd0);
    txn(RQ_LOAD, SZ_8B, 40'h00, 64'd0, 4'd0, RT_LOAD_RET, 64'd0, 64'h01234567_89ABCDEF);

    // Byte store to lane 3 only.
    txn(RQ_STORE, SZ_1B, 40'h0B, 64'hFFFFFFAA_FFFFFFFF, 4'd0, RT_ST_ACK, 64'd0, 64'd0);
    txn(RQ_LOAD, SZ_8B, 40'h08, 64'd0, 4'd0, RT_LOAD_RET, 64'd0, 64'h012345AA_89ABCDEF);

    // A 2B store at offset 7 rounds down to lanes 6-7. Its address is past
    // DEPTH*8, so it wraps onto word 1.
    txn(RQ_STORE, SZ_2B, 40'h8F, 64'hFFFFFFFF_FFFF1234, 4'd0, RT_ST_ACK, 64'd0, 64'd0);
    txn(RQ_LOAD, SZ_8B, 40'h00, 64'd0, 4'd0, RT_LOAD_RET, 64'd0, 64'h012345AA_89AB1234);

    // A 4B store at offset 5 rounds down to lanes 4-7.
    txn(RQ_STORE, SZ_4B, 40'h0D, 64'hFFFFFFFF_DEADBEEF, 4'd0, RT_ST_ACK, 64'd0, 64'd0);

    // An illegal size and an unknown request type: ST_ACK, no memory effect.
    txn(RQ_STORE, 3'b100, 40'h08, 64'hFFFFFFFF_FFFFFFFF, 4'd0, RT_ST_ACK, 64'd0, 64'd0);
    txn(5'b00010, SZ_8B, 40'h08, 64'hFFFFFFFF_FFFFFFFF, 4'd0, RT_ST_ACK, 64'd0, 64'd0);
    txn(RQ_LOAD, SZ_8B, 40'h08, 64'd0, 4'd0, RT_LOAD_RET, 64'd0, M1);

    // AMO ADD 4B of 5 onto 7 in lanes 0-3.
    txn(RQ_STORE, SZ_8B, 40'h00, 64'h00000007_11111111, 4'd0, RT_ST_ACK, 64'd0, 64'd0);
`ifdef L15_RESPONDER_AMO_EN
    txn(RQ_AMO, SZ_4B, 40'h00, 64'h00000005_00000000, L15_AMO_OP_ADD,
        RT_ATOMIC_RET, 64'h00000007_00000000, 64'd0);
    txn(RQ_AMO, SZ_4B, 40'h04, 64'h00000000_FFFFFFFF, L15_AMO_OP_XOR,
        RT_ATOMIC_RET, 64'h00000000_11111111, 64'd0);
`else
    txn(RQ_AMO, SZ_4B, 40'h00, 64'h00000005_00000000, L15_AMO_OP_ADD,
        RT_ST_ACK, 64'd0, 64'd0);
`endif
    txn(RQ_LOAD, SZ_8B, 40'h00, 64'd0, 4'd0, RT_LOAD_RET, M0, M1);

    // Hold the response for 10 cycles while a new request is already
    // pending. That request is acked only one cycle after req_ack.
    issue(RQ_LOAD, SZ_8B, 40'h08, 64'd0, 4'd0, RT_LOAD_RET, M0, M1);
    drive(RQ_LOAD, SZ_8B, 40'h00, 64'd0, 4'd0);
    hold_resp(10, RT_LOAD_RET, M0, M1);
    ack_resp();
    txn(RQ_LOAD, SZ_8B, 40'h00, 64'd0, 4'd0, RT_LOAD_RET, M0, M1);

    // Reset in WAIT clears the outputs at once and wipes the memory.
    drive(RQ_LOAD, SZ_8B, 40'h08, 64'd0, 4'd0);
    @(posedge clk); #1;
    chk("pre_reset_ack", 64'(bus.l15_transducer_ack), 64'd1);
    bus.transducer_l15_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    txn(RQ_LOAD, SZ_8B, 40'h08, 64'd0, 4'd0, RT_LOAD_RET, 64'd0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l15_scratch_responder.md
# l15_scratch_responder

Behavioural stand-in for the L1.5 on the core-side request/response interface. It accepts a single outstanding request from a core transducer, acknowledges it, and services it from a small internal scratch memory. After a programmable latency it returns a response and holds it until the transducer acknowledges it. It sits in place of the L1.5 in tile-level bring-up and transducer verification benches, at the opposite end of the same signals the transducer drives.

## Interface
Parameters:
- `DEPTH`, 16: scratch memory size in 64-bit words; power of two, ≥2.
- `RESP_LAT`, 2: idle cycles between the ack cycle and response valid; 0..255.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `transducer_l15_val`  in  1  request valid; held by the requester until `l15_transducer_ack`.
- `transducer_l15_rqtype`  in  5  request type.
- `transducer_l15_amo_op`  in  `L15_AMO_OP_WIDTH`  atomic operation.
- `transducer_l15_size`  in  3  access size.
- `transducer_l15_address`  in  `PHY_ADDR_WIDTH`  byte address.
- `transducer_l15_data`  in  64  store or AMO operand, big-endian lanes.
- `transducer_l15_nc`  in  1  non-cacheable; ignored.
- `l15_transducer_ack`  out  1  request accepted.
- `l15_transducer_header_ack`  out  1  request header accepted; identical to `ack`.
- `l15_transducer_val`  out  1  response valid.
- `l15_transducer_returntype`  out  4  response type.
- `l15_transducer_data_0`  out  64  response data, even word.
- `l15_transducer_data_1`  out  64  response data, odd word.
- `transducer_l15_req_ack`  in  1  response consumed.

## Operation
- Request types:
  - LOAD 5'b00000 returns LOAD_RET 4'b0000.
  - STORE 5'b00001 returns ST_ACK 4'b0100.
  - AMO 5'b00110 returns ATOMIC_RET 4'b0011 (see Configuration).
  - Any other type returns ST_ACK with no memory effect.
- Word index: `idx = address[3 +: log2(DEPTH)]`. Higher address bits are ignored, so the index wraps modulo DEPTH.
- Byte lane k (address offset k) occupies data bits [63-8k -: 8].
- Size encodings: 3'b000 = 1B, 3'b001 = 2B, 3'b010 = 4B, 3'b011 = 8B. The byte mask covers `size` bytes starting at `address[2:0]` rounded down to a size multiple. Sizes 3'b100 and above: no write, return ST_ACK.
- LOAD:
  - `data_0 = mem[{idx[msb:1],1'b0}]`.
  - `data_1 = mem[{idx[msb:1],1'b1}]`.
- STORE: merge the masked lanes of `transducer_l15_data` into `mem[idx]`. Response data is zero.
- FSM states: IDLE, ACK, WAIT, RESP.
  - IDLE→ACK when `transducer_l15_val`=1; the request fields are registered.
  - ACK→WAIT when `RESP_LAT`>0; ACK→RESP directly when `RESP_LAT`=0. Memory update and response-data capture happen on this edge.
  - WAIT→RESP when the latency counter reaches `RESP_LAT`-1.
  - RESP→IDLE when `transducer_l15_req_ack`=1.
- Outputs by state:
  - `ack` and `header_ack` are 1 only in ACK.
  - `l15_transducer_val` is 1 only in RESP.
  - `returntype` and `data` are stable throughout RESP.
- Boundary conditions:
  - `transducer_l15_val` outside IDLE is ignored; the requester holds it.
  - `req_ack` outside RESP is ignored.
  - Reset at any point returns the FSM to IDLE and zeroes all outputs, registers and memory.

## Timing
- Request seen in IDLE in cycle T: `ack` in T+1, response valid from T+2+`RESP_LAT`.
- Response held until `req_ack`; on a `req_ack` in cycle R, the earliest next accept is in R+1 (ack in R+2).
- Reset values: every output 0; memory all-zero.
- Throughput: one request in flight; no pipelining.

## Configuration
- `L15_RESPONDER_AMO_EN` defined:
  - AMO is supported for sizes 4B and 8B with ops ADD, AND, OR, XOR and SWAP.
  - The old masked value is returned in `data_0` (`data_1` = 0). The new value is written in the same edge as a store.
  - Unsupported ops or sizes return the old value with no write.
- Undefined: AMO is treated as an unknown type (ST_ACK, no effect) and the AMO datapath is not compiled.

## Structure
- Shared package or defines holds:
  - rqtype and returntype codes;
  - size codes;
  - AMO op codes (existing `L15_AMO_OP_*`);
  - FSM state encoding.
- Sub-module `l15_scratch_lane_mask`: computes the 8-bit byte mask from size and `address[2:0]`; used by both STORE and AMO.

## Test plan
- LOAD from reset, address 0x10 → ack one cycle after val, response after `RESP_LAT`+2, LOAD_RET, `data_0` = `data_1` = 0.
- STORE 8B 0x0123456789ABCDEF at 0x08, then LOAD 0x00 → ST_ACK, then `data_1` = 0x0123456789ABCDEF, `data_0` = 0.
- STORE 1B 0xAA at 0x0B → `mem[1]` byte lane 3 = 0xAA only, other lanes unchanged. Then STORE at 0x08 + DEPTH*8 → wraps onto `mem[1]`.
- With `L15_RESPONDER_AMO_EN`: AMO ADD 4B operand 5 at 0x00 where the word holds 7 → ATOMIC_RET with old value 7 in lane 0-3 position; a subsequent LOAD shows 12.
- Hold `req_ack` low 10 cycles → val, returntype and data stable. Meanwhile drive a new val → no ack until one cycle after `req_ack`.
- Assert `rst` during WAIT → all outputs 0 immediately; the following LOAD completes normally and returns zero data.
